// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, bubble encoding and FSM state encoding
// for the instruction fetch stage.
package fetch_unit_pkg;
    localparam int          PC_W_DEF  = 16;       // default PC / address width
    localparam int          INSTR_W   = 16;       // instruction word width
    localparam logic [15:0] NOP_INSTR = 16'h0000; // bubble instruction encoding

    // REQ:     request outstanding at PC
    // HOLD:    word accepted during a stall, parked in the buffer
    // DISCARD: in-flight request must be dropped once it is accepted
    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// fetch_unit_if_id_reg: IF/ID pipeline register.
// Ports:
//   clk, rst            clock, async active-high reset
//   i_clear             squash to a bubble (wins over i_load)
//   i_load              capture i_instr / i_pc_next as a valid instruction
//   (neither)           hold current contents
//   o_valid/o_instr/o_pc_next  register contents
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc_next,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc_next
);
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_instr   <= NOP_INSTR;
            r_pc_next <= '0;
        end else if (i_clear) begin
            r_valid   <= 1'b0;
            r_instr   <= NOP_INSTR;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_instr   <= i_instr;
            r_pc_next <= i_pc_next;
        end
    end

    assign o_valid   = r_valid;
    assign o_instr   = r_instr;
    assign o_pc_next = r_pc_next;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, fetch FSM and instruction-memory handshake,
// feeding the IF/ID register.
// Ports:
//   clk, rst                       clock, async active-high reset
//   stall, flush, redirect_pc      hazard-unit controls (flush beats stall)
//   imem_req, imem_addr            request to instruction memory
//   imem_ready, imem_rdata         acceptance with same-cycle data
//   if_id_valid/instr/pc_next      IF/ID register outputs
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_next
);
    fetch_state_e       r_state, w_state_n;
    logic [PC_W-1:0]    r_pc, w_pc_n;
    logic [PC_W-1:0]    r_tgt, w_tgt_n;
    logic [INSTR_W-1:0] r_buf, w_buf_n;
    logic               w_load, w_clear;
    logic [INSTR_W-1:0] w_load_instr;
    logic [PC_W-1:0]    w_pc_inc;

    assign w_pc_inc = r_pc + 1'b1; // wraps modulo 2^PC_W

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_tgt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_tgt   <= w_tgt_n;
            r_buf   <= w_buf_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_tgt_n      = r_tgt;
        w_buf_n      = r_buf;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_load_instr = imem_rdata;
        case (r_state)
            ST_REQ: begin
                if (flush) begin
                    w_clear = 1'b1;
                    if (imem_ready) begin
                        w_pc_n = redirect_pc;
                    end else begin
                        // Request cannot be withdrawn; remember where to go.
                        w_tgt_n   = redirect_pc;
                        w_state_n = ST_DISCARD;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        w_buf_n   = imem_rdata;
                        w_state_n = ST_HOLD;
                    end else begin
                        w_load = 1'b1;
                        w_pc_n = w_pc_inc;
                    end
                end else if (!stall) begin
                    w_clear = 1'b1; // no word this cycle: bubble
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    w_clear   = 1'b1;
                    w_buf_n   = '0;
                    w_pc_n    = redirect_pc;
                    w_state_n = ST_REQ;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_buf;
                    w_pc_n       = w_pc_inc;
                    w_state_n    = ST_REQ;
                end
            end
            ST_DISCARD: begin
                w_clear = 1'b1;
                if (imem_ready) begin
                    // Returned word is dropped; a same-cycle flush is the latest.
                    w_pc_n    = flush ? redirect_pc : r_tgt;
                    w_state_n = ST_REQ;
                end else if (flush) begin
                    w_tgt_n = redirect_pc;
                end
            end
            default: begin
                w_state_n = ST_REQ;
            end
        endcase
    end

    // In DISCARD the PC still holds the in-flight address.
    assign imem_req  = (r_state != ST_HOLD);
    assign imem_addr = r_pc;

    fetch_unit_if_id_reg #(.PC_W(PC_W)) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_clear   (w_clear),
        .i_instr   (w_load_instr),
        .i_pc_next (w_pc_inc),
        .o_valid   (if_id_valid),
        .o_instr   (if_id_instr),
        .o_pc_next (if_id_pc_next)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_next;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc_next (if_id_pc_next)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; memory returns 16'h1000 + address.
    task automatic cyc(input logic r, input logic s, input logic f, input logic [15:0] rp);
        imem_ready  = r;
        stall       = s;
        flush       = f;
        redirect_pc = rp;
        imem_rdata  = 16'h1000 + imem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [15:0] ins,
                            input logic [15:0] pcn, input logic [15:0] addr);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".instr"}, {16'd0, if_id_instr}, {16'd0, ins});
            chk({tag, ".pcn"}, {16'd0, if_id_pc_next}, {16'd0, pcn});
        end
        chk({tag, ".addr"}, {16'd0, imem_addr}, {16'd0, addr});
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst.instr", {16'd0, if_id_instr}, 32'd0);
        chk("rst.pcn", {16'd0, if_id_pc_next}, 32'd0);
        chk("rst.req", {31'd0, imem_req}, 32'd1);
        chk("rst.addr", {16'd0, imem_addr}, 32'd0);
        rst = 1'b0;

        // Sequential fetch
        cyc(1, 0, 0, 0); chk_ifid("seq0", 1, 16'h1000, 16'd1, 16'd1);
        cyc(1, 0, 0, 0); chk_ifid("seq1", 1, 16'h1001, 16'd2, 16'd2);
        cyc(1, 0, 0, 0); chk_ifid("seq2", 1, 16'h1002, 16'd3, 16'd3);
        cyc(1, 0, 0, 0); chk_ifid("seq3", 1, 16'h1003, 16'd4, 16'd4);
        cyc(1, 0, 0, 0); chk_ifid("seq4", 1, 16'h1004, 16'd5, 16'd5);

        // Stall 3 cycles, asserted as 16'h1005 is accepted
        cyc(1, 1, 0, 0); chk("st1.req", {31'd0, imem_req}, 32'd0);
        chk_ifid("st1", 1, 16'h1004, 16'd5, 16'd5);
        cyc(1, 1, 0, 0); chk("st2.req", {31'd0, imem_req}, 32'd0);
        chk_ifid("st2", 1, 16'h1004, 16'd5, 16'd5);
        cyc(1, 1, 0, 0); chk("st3.req", {31'd0, imem_req}, 32'd0);
        chk_ifid("st3", 1, 16'h1004, 16'd5, 16'd5);
        cyc(0, 0, 0, 0); chk("rel.req", {31'd0, imem_req}, 32'd1);
        chk_ifid("rel", 1, 16'h1005, 16'd6, 16'd6);
        cyc(1, 0, 0, 0); chk_ifid("post", 1, 16'h1006, 16'd7, 16'd7);

        // Flush with ready
        cyc(1, 0, 1, 16'h0040); chk_ifid("flr", 0, 16'h0, 16'h0, 16'h0040);
        cyc(1, 0, 0, 0); chk_ifid("flr1", 1, 16'h1040, 16'h0041, 16'h0041);

        // Flush without ready, 4 cycles not ready
        cyc(0, 0, 1, 16'h0080); chk_ifid("fln0", 0, 16'h0, 16'h0, 16'h0041);
        chk("fln0.req", {31'd0, imem_req}, 32'd1);
        cyc(0, 0, 0, 0); chk_ifid("fln1", 0, 16'h0, 16'h0, 16'h0041);
        cyc(0, 0, 0, 0); chk_ifid("fln2", 0, 16'h0, 16'h0, 16'h0041);
        cyc(0, 0, 0, 0); chk_ifid("fln3", 0, 16'h0, 16'h0, 16'h0041);
        cyc(1, 0, 0, 0); chk_ifid("fln4", 0, 16'h0, 16'h0, 16'h0080);
        cyc(1, 0, 0, 0); chk_ifid("fln5", 1, 16'h1080, 16'h0081, 16'h0081);

        // Two flushes while discarding: latest target wins
        cyc(0, 0, 1, 16'h0020); chk_ifid("dd0", 0, 16'h0, 16'h0, 16'h0081);
        cyc(0, 0, 1, 16'h0030); chk_ifid("dd1", 0, 16'h0, 16'h0, 16'h0081);
        cyc(1, 0, 0, 0); chk_ifid("dd2", 0, 16'h0, 16'h0, 16'h0030);
        cyc(1, 0, 0, 0); chk_ifid("dd3", 1, 16'h1030, 16'h0031, 16'h0031);

        // Stall+flush in HOLD
        cyc(1, 1, 0, 0); chk("hf0.req", {31'd0, imem_req}, 32'd0);
        cyc(0, 1, 1, 16'h0010); chk_ifid("hf1", 0, 16'h0, 16'h0, 16'h0010);
        chk("hf1.req", {31'd0, imem_req}, 32'd1);
        cyc(1, 0, 0, 0); chk_ifid("hf2", 1, 16'h1010, 16'h0011, 16'h0011);

        // Wrap at 16'hFFFF
        cyc(1, 0, 1, 16'hFFFF); chk_ifid("wr0", 0, 16'h0, 16'h0, 16'hFFFF);
        cyc(1, 0, 0, 0); chk_ifid("wr1", 1, 16'h0FFF, 16'h0000, 16'h0000);
        cyc(1, 0, 0, 0); chk_ifid("wr2", 1, 16'h1000, 16'h0001, 16'h0001);

        // Async reset mid-request, between clock edges
        imem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst.instr", {16'd0, if_id_instr}, 32'd0);
        chk("arst.pcn", {16'd0, if_id_pc_next}, 32'd0);
        chk("arst.addr", {16'd0, imem_addr}, 32'd0);
        chk("arst.req", {31'd0, imem_req}, 32'd1);
        #3 rst = 1'b0;
        cyc(1, 0, 0, 0); chk_ifid("arst1", 1, 16'h1000, 16'h0001, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
